ov7670_frame_sequencer: RTL
===========================

OV7670_FRAME_SEQUENCER -- requirements
Module: ov7670_frame_sequencer

Interface
REQ-001 Parameter FRAME_BYTES, default 153600, SHALL set the bytes per frame (320x240 RGB565); legal range 1 to 262143.
REQ-002 Parameter RCLK_HALF, default 2, SHALL set the clk cycles per rclk phase (high or low); minimum 1.
REQ-003 Parameter WRST_CYCLES, default 4, SHALL set the clk cycles for which wrst is held low.
REQ-004 clk  in  1  100MHz system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cam_ready  in  1  SCCB configuration complete; level.
REQ-007 capture_req  in  1  single-cycle request to capture and ship one frame.
REQ-008 abort  in  1  synchronous abort; return to IDLE.
REQ-009 vsync  in  1  camera VSYNC; asynchronous, 2-flop synchronized.
REQ-010 wr  out  1  AL422B write enable; active high.
REQ-011 wrst  out  1  AL422B write-pointer reset; active low.
REQ-012 rclk  out  1  AL422B read clock.
REQ-013 rrst  out  1  AL422B read-pointer reset; active low.
REQ-014 oe  out  1  AL422B output enable; active low.
REQ-015 d_in  in  8  AL422B read data.
REQ-016 d_out  out  8  byte presented to the RPi.
REQ-017 valid  out  1  d_out valid (4-phase handshake).
REQ-018 ack  in  1  RPi acknowledge; asynchronous, 2-flop synchronized.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 frame_done  out  1  one-cycle pulse when the final byte's ack has completed.
REQ-021 state_out  out  3  current state encoding (debug).
REQ-022 byte_cnt_out  out  18  bytes handed off in the current frame (debug).

Function
REQ-023 The state machine SHALL use these encodings: IDLE=0, ARM=1, CAPTURE=2, RRST=3, FETCH=4, PRESENT=5, RELEASE=6, DONE=7.
REQ-024 IDLE: on capture_req=1 with cam_ready=1, SHALL go to ARM; capture_req while cam_ready=0 SHALL be ignored.
REQ-025 ARM: on a synchronized vsync rising edge, SHALL drive wrst=0 for WRST_CYCLES cycles, then set wr=1 and go to CAPTURE.
REQ-026 CAPTURE: wr SHALL stay 1 until the next synchronized vsync rising edge; at that edge wr=0 and the state goes to RRST.
REQ-027 RRST: SHALL hold rrst=0 for exactly two full rclk periods, then set rrst=1, oe=0, clear byte_cnt, and go to FETCH.
REQ-028 FETCH: SHALL drive rclk high for RCLK_HALF cycles, then low for RCLK_HALF cycles.
REQ-029 FETCH: on the clk edge where rclk goes high-to-low, d_in SHALL be registered into d_out and the state SHALL go to PRESENT after the low phase.
REQ-030 PRESENT: valid=1 and d_out SHALL be held stable until synchronized ack=1, then valid=0 and the state goes to RELEASE.
REQ-031 RELEASE: wait for synchronized ack=0, then increment byte_cnt.
REQ-032 RELEASE exit: if the new byte_cnt equals FRAME_BYTES, go to DONE; otherwise go to FETCH.
REQ-033 DONE: SHALL pulse frame_done for one cycle, set oe=1, and return to IDLE.
REQ-034 The vsync edge detector SHALL run continuously, but edges SHALL be acted on only in ARM and CAPTURE.
REQ-035 capture_req outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-036 abort=1 in any state SHALL force IDLE on the next cycle with wr=0, valid=0, rrst=1, wrst=1, oe=1, rclk=0, byte_cnt=0; abort takes priority over any concurrent transition.
REQ-037 When cam_ready drops in ARM or CAPTURE, the block SHALL behave as if abort were asserted; in later states it SHALL be ignored.
REQ-038 byte_cnt SHALL be 18 bits and SHALL never exceed FRAME_BYTES (no wrap).
REQ-039 Handshake latency: valid SHALL rise 2*RCLK_HALF+1 clk cycles after FETCH entry.

Reset
REQ-040 While reset_n=0, outputs SHALL be: state IDLE, wr=0, wrst=1, rclk=0, rrst=1, oe=1, d_out=0, valid=0, busy=0, frame_done=0, byte_cnt=0; synchronizer flops SHALL be cleared to 0.
REQ-041 Reset SHALL take effect asynchronously mid-operation, and the block SHALL start in IDLE on the first clk edge after reset_n rises.

Verification
REQ-042 Full frame (FRAME_BYTES=4, RCLK_HALF=2): cam_ready=1, capture_req, two vsync pulses, FIFO model returns 0xA1..0xA4, RPi model acks -> d_out sequence A1,A2,A3,A4; one frame_done; state_out back to 0.
REQ-043 Write window: after the first vsync edge -> wrst low for exactly 4 cycles, then wr=1 until the second vsync edge + 2-flop delay.
REQ-044 Slow ack: ack held off 50 cycles -> valid and d_out stable throughout, no extra rclk pulses, byte_cnt unchanged.
REQ-045 Abort: abort asserted in PRESENT with byte_cnt=2 -> next cycle valid=0, oe=1, state_out=0, byte_cnt_out=0, no frame_done.
REQ-046 Gating: capture_req with cam_ready=0 -> stays IDLE; capture_req during CAPTURE -> ignored, exactly one frame_done.
REQ-047 Reset: reset_n pulsed low during FETCH -> all outputs at reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ov7670_frame_sequencer_if.sv
// Bus between the frame sequencer, the AL422B FIFO read/write controls and the RPi byte
// handshake. The sequencer uses the master modport.
interface ov7670_frame_sequencer_if;
    logic       wr;
    logic       wrst;
    logic       rclk;
    logic       rrst;
    logic       oe;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       valid;
    logic       ack;

    modport master (
        output wr, wrst, rclk, rrst, oe, d_out, valid,
        input  d_in, ack
    );

    modport slave (
        input  wr, wrst, rclk, rrst, oe, d_out, valid,
        output d_in, ack
    );
endinterface

// File: rtl/ov7670_frame_sequencer.sv
// Captures one OV7670 frame into an AL422B FIFO between two VSYNC edges, then reads it back
// byte by byte to the RPi over a 4-phase valid/ack handshake.
module ov7670_frame_sequencer #(
    parameter int unsigned FRAME_BYTES = 153600,
    parameter int unsigned RCLK_HALF   = 2,
    parameter int unsigned WRST_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cam_ready,
    input  logic                           capture_req,
    input  logic                           abort,
    input  logic                           vsync,
    ov7670_frame_sequencer_if.master       bus,
    output logic                           busy,
    output logic                           frame_done,
    output logic [2:0]                     state_out,
    output logic [17:0]                    byte_cnt_out
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArm     = 3'd1,
        StCapture = 3'd2,
        StRrst    = 3'd3,
        StFetch   = 3'd4,
        StPresent = 3'd5,
        StRelease = 3'd6,
        StDone    = 3'd7
    } state_e;

    // One counter serves both the wrst pulse and the rclk half-period timing.
    localparam int unsigned CntMax = (RCLK_HALF > WRST_CYCLES) ? RCLK_HALF : WRST_CYCLES;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);
    localparam logic [CntW-1:0] HalfLast   = CntW'(RCLK_HALF - 1);
    localparam logic [CntW-1:0] WrstLast   = CntW'(WRST_CYCLES - 1);
    localparam logic [17:0]     FrameBytes = 18'(FRAME_BYTES);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      rclk_edges_q, rclk_edges_d;
    logic [17:0]     byte_cnt_q, byte_cnt_d;
    logic [17:0]     byte_cnt_inc;
    logic            wr_q, wr_d;
    logic            wrst_q, wrst_d;
    logic            rclk_q, rclk_d;
    logic            rrst_q, rrst_d;
    logic            oe_q, oe_d;
    logic [7:0]      d_out_q, d_out_d;
    logic            valid_q, valid_d;
    logic            frame_done_q, frame_done_d;

    logic            vsync_meta_q, vsync_sync_q, vsync_prev_q;
    logic            ack_meta_q, ack_sync_q;
    logic            vsync_rise;
    logic            force_idle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_meta_q <= 1'b0;
            vsync_sync_q <= 1'b0;
            vsync_prev_q <= 1'b0;
            ack_meta_q   <= 1'b0;
            ack_sync_q   <= 1'b0;
        end else begin
            vsync_meta_q <= vsync;
            vsync_sync_q <= vsync_meta_q;
            vsync_prev_q <= vsync_sync_q;
            ack_meta_q   <= bus.ack;
            ack_sync_q   <= ack_meta_q;
        end
    end

    assign vsync_rise   = vsync_sync_q & ~vsync_prev_q;
    assign byte_cnt_inc = byte_cnt_q + 18'd1;
    // Losing the camera only matters while the write side is still being set up or filled.
    assign force_idle   = abort | (~cam_ready & ((state_q == StArm) | (state_q == StCapture)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rclk_edges_d = rclk_edges_q;
        byte_cnt_d   = byte_cnt_q;
        wr_d         = wr_q;
        wrst_d       = wrst_q;
        rclk_d       = rclk_q;
        rrst_d       = rrst_q;
        oe_d         = oe_q;
        d_out_d      = d_out_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (capture_req && cam_ready) begin
                    state_d = StArm;
                end
            end

            StArm: begin
                // wrst low marks the reset pulse in progress after the first vsync edge.
                if (!wrst_q) begin
                    if (cnt_q == WrstLast) begin
                        wrst_d  = 1'b1;
                        wr_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = StCapture;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (vsync_rise) begin
                    wrst_d = 1'b0;
                    cnt_d  = '0;
                end
            end

            StCapture: begin
                if (vsync_rise) begin
                    wr_d         = 1'b0;
                    rrst_d       = 1'b0;
                    rclk_d       = 1'b1;
                    cnt_d        = '0;
                    rclk_edges_d = '0;
                    state_d      = StRrst;
                end
            end

            StRrst: begin
                // Four half-periods of rclk with rrst low: two full read-clock periods.
                if (cnt_q == HalfLast) begin
                    cnt_d        = '0;
                    rclk_d       = ~rclk_q;
                    rclk_edges_d = rclk_edges_q + 2'd1;
                    if (rclk_edges_q == 2'd3) begin
                        rrst_d     = 1'b1;
                        oe_d       = 1'b0;
                        byte_cnt_d = '0;
                        state_d    = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StFetch: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (rclk_q) begin
                        rclk_d  = 1'b0;
                        d_out_d = bus.d_in;
                    end else begin
                        state_d = StPresent;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StPresent: begin
                if (ack_sync_q) begin
                    valid_d = 1'b0;
                    state_d = StRelease;
                end else begin
                    valid_d = 1'b1;
                end
            end

            StRelease: begin
                if (!ack_sync_q) begin
                    byte_cnt_d = byte_cnt_inc;
                    if (byte_cnt_inc == FrameBytes) begin
                        oe_d         = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = StDone;
                    end else begin
                        rclk_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StFetch;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (force_idle) begin
            state_d      = StIdle;
            cnt_d        = '0;
            rclk_edges_d = '0;
            byte_cnt_d   = '0;
            wr_d         = 1'b0;
            wrst_d       = 1'b1;
            rclk_d       = 1'b0;
            rrst_d       = 1'b1;
            oe_d         = 1'b1;
            valid_d      = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rclk_edges_q <= '0;
            byte_cnt_q   <= '0;
            wr_q         <= 1'b0;
            wrst_q       <= 1'b1;
            rclk_q       <= 1'b0;
            rrst_q       <= 1'b1;
            oe_q         <= 1'b1;
            d_out_q      <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rclk_edges_q <= rclk_edges_d;
            byte_cnt_q   <= byte_cnt_d;
            wr_q         <= wr_d;
            wrst_q       <= wrst_d;
            rclk_q       <= rclk_d;
            rrst_q       <= rrst_d;
            oe_q         <= oe_d;
            d_out_q      <= d_out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.wr       = wr_q;
    assign bus.wrst     = wrst_q;
    assign bus.rclk     = rclk_q;
    assign bus.rrst     = rrst_q;
    assign bus.oe       = oe_q;
    assign bus.d_out    = d_out_q;
    assign bus.valid    = valid_q;
    assign busy         = (state_q != StIdle);
    assign frame_done   = frame_done_q;
    assign state_out    = state_q;
    assign byte_cnt_out = byte_cnt_q;

endmodule
